rv_instr_encoder: RTL and testbench

Sequential RV32I instruction encoder: the inverse of the control-unit main decoder. It accepts instruction descriptors (kind, registers, funct fields, immediate), range-checks the immediate and packs a 32-bit instruction word in the opcode/format set the decoder recognises: R-type, I-type ALU, lw, sw, beq and jal. Each word is paired with an auto-incrementing instruction-memory word address. It sits between the boot/program loader (or testbench stimulus generator) and the instruction-memory write port, with valid/ready handshakes on both sides.

---
 rtl/rv_instr_encoder.sv | 174 +++++++++++++++++
 tb/tb_rv_instr_encoder.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_instr_encoder.sv
// RV32I instruction encoder: descriptor in, packed instruction word plus
// instruction-memory word address out, through a two-stage valid/ready pipeline.
module rv_instr_encoder #(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_count
);

  localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [31:0]       L_NOP  = 32'h0000_0013;

  localparam logic [2:0] K_R   = 3'd0;
  localparam logic [2:0] K_I   = 3'd1;
  localparam logic [2:0] K_LW  = 3'd2;
  localparam logic [2:0] K_SW  = 3'd3;
  localparam logic [2:0] K_BEQ = 3'd4;
  localparam logic [2:0] K_JAL = 3'd5;

  // stage 1: captured descriptor
  logic              r_s1_valid;
  logic [2:0]        r_s1_kind;
  logic [4:0]        r_s1_rd;
  logic [4:0]        r_s1_rs1;
  logic [4:0]        r_s1_rs2;
  logic [2:0]        r_s1_f3;
  logic [6:0]        r_s1_f7;
  logic [20:0]       r_s1_imm;
  logic [ADDR_W-1:0] r_s1_addr;
  logic              r_s1_err;

  // stage 2: encoded word, drives all outputs
  logic              r_s2_valid;
  logic [31:0]       r_s2_instr;
  logic [ADDR_W-1:0] r_s2_addr;
  logic              r_s2_err;

  logic [ADDR_W-1:0] r_cnt;
  logic [7:0]        r_err_cnt;

  logic              w_s2_adv;
  logic              w_s1_adv;
  logic              w_accept;
  logic              w_deliver;
  logic [ADDR_W-1:0] w_addr;
  logic signed [31:0] w_imm_s;
  logic              w_in_err;
  logic [31:0]       w_enc;

  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign w_accept  = in_valid && w_s1_adv;
  assign w_deliver = r_s2_valid && out_ready;
  assign w_addr    = start ? L_BASE : r_cnt;
  assign w_imm_s   = $signed(in_imm);

  always_comb begin
    w_in_err = 1'b0;
    case (in_kind)
      K_R:               w_in_err = 1'b0;
      K_I, K_LW, K_SW:   w_in_err = (w_imm_s < -32'sd2048) || (w_imm_s > 32'sd2047);
      K_BEQ:             w_in_err = (w_imm_s < -32'sd4096) || (w_imm_s > 32'sd4094) || in_imm[0];
      K_JAL:             w_in_err = (w_imm_s < -32'sd1048576) || (w_imm_s > 32'sd1048574)
                                    || in_imm[0];
      default:           w_in_err = 1'b1;
    endcase
  end

  always_comb begin
    w_enc = L_NOP;
    if (!r_s1_err) begin
      case (r_s1_kind)
        K_R:   w_enc = {r_s1_f7, r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_rd, 7'b0110011};
        K_I:   w_enc = {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, 7'b0010011};
        K_LW:  w_enc = {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, 7'b0000011};
        K_SW:  w_enc = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_imm[4:0],
                        7'b0100011};
        K_BEQ: w_enc = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, 3'b000,
                        r_s1_imm[4:1], r_s1_imm[11], 7'b1100011};
        K_JAL: w_enc = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12],
                        r_s1_rd, 7'b1101111};
        default: w_enc = L_NOP;
      endcase
    end
  end

  // a start coincident with an accept gives that descriptor BASE_ADDR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= L_BASE;
    end else if (w_accept) begin
      r_cnt <= w_addr + ADDR_W'(1);
    end else if (start) begin
      r_cnt <= L_BASE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_kind  <= '0;
      r_s1_rd    <= '0;
      r_s1_rs1   <= '0;
      r_s1_rs2   <= '0;
      r_s1_f3    <= '0;
      r_s1_f7    <= '0;
      r_s1_imm   <= '0;
      r_s1_addr  <= '0;
      r_s1_err   <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_kind <= in_kind;
        r_s1_rd   <= in_rd;
        r_s1_rs1  <= in_rs1;
        r_s1_rs2  <= in_rs2;
        r_s1_f3   <= in_funct3;
        r_s1_f7   <= in_funct7;
        r_s1_imm  <= in_imm[20:0];
        r_s1_addr <= w_addr;
        r_s1_err  <= w_in_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_instr <= '0;
      r_s2_addr  <= '0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_instr <= w_enc;
        r_s2_addr  <= r_s1_addr;
        r_s2_err   <= r_s1_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_deliver && r_s2_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_instr = r_s2_instr;
  assign out_addr  = r_s2_addr;
  assign out_err   = r_s2_err;
  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Scoreboard bench for rv_instr_encoder; a second instance with ADDR_W=2
// shares the stimulus to exercise address wrap.
module tb_rv_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_kind = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_err;
  logic [31:0] out_instr;
  logic [9:0]  out_addr;
  logic [7:0]  err_count;

  logic        in_ready2, out_valid2, out_err2;
  logic [31:0] out_instr2;
  logic [1:0]  out_addr2;
  logic [7:0]  err_count2;

  rv_instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .err_count(err_count));

  rv_instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
    .out_addr(out_addr2), .out_err(out_err2), .err_count(err_count2));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [9:0]  addr;
    logic        err;
  } item_t;

  item_t      exp_q[$];
  item_t      got_q[$];
  int         got_cyc_q[$];
  logic [1:0] got2_q[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  // five reference descriptors; the beq entry carries a nonzero funct3 that must be dropped
  logic [2:0]  t_kind [5] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5};
  logic [4:0]  t_rd   [5] = '{5'd3, 5'd5, 5'd0, 5'd0, 5'd1};
  logic [4:0]  t_rs1  [5] = '{5'd1, 5'd2, 5'd2, 5'd1, 5'd0};
  logic [4:0]  t_rs2  [5] = '{5'd2, 5'd0, 5'd5, 5'd2, 5'd0};
  logic [2:0]  t_f3   [5] = '{3'd0, 3'd2, 3'd2, 3'd7, 3'd0};
  logic [31:0] t_imm  [5] = '{32'd0, 32'd8, 32'd12, 32'hFFFF_FFF8, 32'd16};
  logic [31:0] t_exp  [5] = '{32'h002081B3, 32'h00812283, 32'h00512623,
                              32'hFE208CE3, 32'h010000EF};

  always @(posedge clk) cyc <= cyc + 1;

  // handshakes are decided by values stable at the falling edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got_q.push_back('{instr: out_instr, addr: out_addr, err: out_err});
      got_cyc_q.push_back(cyc);
    end
    if (!rst && out_valid2 && out_ready) got2_q.push_back(out_addr2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    got_q.delete();
    got_cyc_q.delete();
    got2_q.delete();
  endtask

  task automatic put(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] imm);
    int n = 0;
    in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL put_timeout: in_ready stayed %b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_got(input int k);
    int n = 0;
    while (got_q.size() < k && n < 100) begin
      tick();
      n++;
    end
    if (got_q.size() < k) begin
      total++; bad++;
      $display("FAIL wait_got: got %0d words, required %0d", got_q.size(), k);
    end
    tick();
  endtask

  task automatic test_reset();
    tick();
    total++;
    if ({out_valid, out_instr, out_addr, out_err, err_count} !== 52'd0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b instr=%h addr=%0d err=%b cnt=%0d, required all 0",
               out_valid, out_instr, out_addr, out_err, err_count);
    end
    do_reset();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_reset();
      put(t_kind[i], t_rd[i], t_rs1[i], t_rs2[i], t_f3[i], 7'd0, t_imm[i]);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL single_early[%0d]: out_valid=%b one edge after accept, required 0",
                 i, out_valid);
      end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_instr !== t_exp[i] || out_addr !== 10'd0
          || out_err !== 1'b0) begin
        bad++;
        $display("FAIL single[%0d]: valid=%b instr=%h addr=%0d err=%b, required 1 %h 0 0",
                 i, out_valid, out_instr, out_addr, out_err, t_exp[i]);
      end
    end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{instr: t_exp[i], addr: 10'(i), err: 1'b0});
      put(t_kind[i], t_rd[i], t_rs1[i], t_rs2[i], t_f3[i], 7'd0, t_imm[i]);
    end
    wait_got(5);
    for (int i = 0; i < 5 && got_q.size() > 0; i++) begin
      item_t e, g;
      int    c0, c1;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      c0 = got_cyc_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL stream[%0d]: got %h@%0d err=%b, required %h@%0d err=%b",
                 i, g.instr, g.addr, g.err, e.instr, e.addr, e.err);
      end
      if (got_cyc_q.size() > 0) begin
        c1 = got_cyc_q[0];
        total++;
        if (c1 !== c0 + 1) begin
          bad++;
          $display("FAIL stream_gap[%0d]: next word at cycle %0d, required %0d", i, c1, c0 + 1);
        end
      end
    end
  endtask

  task automatic test_errors();
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back('{instr: 32'h00000013, addr: 10'd0, err: 1'b1});
    put(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    exp_q.push_back('{instr: 32'h00000013, addr: 10'd1, err: 1'b1});
    put(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    exp_q.push_back('{instr: 32'h00000013, addr: 10'd2, err: 1'b1});
    put(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    wait_got(3);
    tick();
    total++;
    if (err_count !== 8'd3) begin
      bad++;
      $display("FAIL err_count3: got %0d, required 3", err_count);
    end
    // limits that must pass, then one just past the jal range
    exp_q.push_back('{instr: 32'h7FF00093, addr: 10'd3, err: 1'b0});
    put(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047);
    exp_q.push_back('{instr: 32'h7E000FE3, addr: 10'd4, err: 1'b0});
    put(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094);
    exp_q.push_back('{instr: 32'h8000006F, addr: 10'd5, err: 1'b0});
    put(3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0000);
    exp_q.push_back('{instr: 32'h00000013, addr: 10'd6, err: 1'b1});
    put(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048576);
    wait_got(7);
    for (int i = 0; i < 7 && got_q.size() > 0; i++) begin
      item_t e, g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL errors[%0d]: got %h@%0d err=%b, required %h@%0d err=%b",
                 i, g.instr, g.addr, g.err, e.instr, e.addr, e.err);
      end
    end
    total++;
    if (err_count !== 8'd4) begin
      bad++;
      $display("FAIL err_count4: got %0d, required 4", err_count);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      exp_q.push_back('{instr: 32'h00208033 | (32'(i + 1) << 7), addr: 10'(i), err: 1'b0});
    put(3'd0, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    put(3'd0, 5'd2, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    in_kind = 3'd0; in_rd = 5'd3; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== exp_q[0].instr) begin
        bad++;
        $display("FAIL bp_hold[%0d]: in_ready=%b valid=%b instr=%h, required 0 1 %h",
                 c, in_ready, out_valid, out_instr, exp_q[0].instr);
      end
      tick();
    end
    out_ready = 1'b1;
    put(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    wait_got(3);
    for (int i = 0; i < 3 && got_q.size() > 0; i++) begin
      item_t e, g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL bp[%0d]: got %h@%0d err=%b, required %h@%0d err=%b",
                 i, g.instr, g.addr, g.err, e.instr, e.addr, e.err);
      end
    end
    total++;
    if (got_q.size() != 0) begin
      bad++;
      $display("FAIL bp_extra: %0d surplus words, required 0", got_q.size());
    end
    n = n + 0;
  endtask

  task automatic test_addr();
    logic [9:0] a1 [7] = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd0, 10'd1};
    logic [1:0] a2 [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back('{instr: 32'h00208033 | (32'(i + 1) << 7), addr: a1[i], err: 1'b0});
      if (i == 5) start = 1'b1;
      put(3'd0, 5'(i + 1), 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    end
    wait_got(7);
    for (int i = 0; i < 7 && got_q.size() > 0 && got2_q.size() > 0; i++) begin
      item_t      e, g;
      logic [1:0] g2;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      g2 = got2_q.pop_front();
      total++;
      if (g !== e || g2 !== a2[i]) begin
        bad++;
        $display("FAIL addr[%0d]: got %h@%0d narrow@%0d, required %h@%0d narrow@%0d",
                 i, g.instr, g.addr, g2, e.instr, e.addr, a2[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    item_t g;
    do_reset();
    out_ready = 1'b1;
    put(3'd6, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    wait_got(1);
    total++;
    if (err_count !== 8'd1) begin
      bad++;
      $display("FAIL pre_rst_cnt: got %0d, required 1", err_count);
    end
    out_ready = 1'b0;
    put(3'd0, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    put(3'd0, 5'd2, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL pre_rst_full: valid=%b in_ready=%b, required 1 0", out_valid, in_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || err_count !== 8'd0) begin
      bad++;
      $display("FAIL async_rst: valid=%b cnt=%0d, required 0 0", out_valid, err_count);
    end
    tick();
    rst = 1'b0;
    got_q.delete();
    got_cyc_q.delete();
    got2_q.delete();
    out_ready = 1'b1;
    put(3'd0, 5'd7, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    wait_got(1);
    total++;
    if (got_q.size() != 1) begin
      bad++;
      $display("FAIL post_rst_words: got %0d words, required 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      total++;
      if (g.instr !== 32'h002083B3 || g.addr !== 10'd0 || err_count !== 8'd0) begin
        bad++;
        $display("FAIL post_rst: got %h@%0d cnt=%0d, required 002083b3@0 cnt=0",
                 g.instr, g.addr, err_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_errors();
    test_backpressure();
    test_addr();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
